// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD adder and its display decoders.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [3:0] BCD_ADJ   = 4'd6;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    // Active-low a..g patterns for decimal digits 0..9, leftmost bit is segment a.
    localparam logic [0:6] SEG_TABLE [0:9] = '{
        7'b0000001,
        7'b1001111,
        7'b0010010,
        7'b0000110,
        7'b1001100,
        7'b0100100,
        7'b0100000,
        7'b0001111,
        7'b0000000,
        7'b0000100
    };

    function automatic logic is_bcd(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_seg7.sv
// Single-digit BCD to active-low seven-segment decoder; non-decimal codes blank the digit.
module bcd_seg7
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [0:6] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (is_bcd(digit)) begin
            seg = SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/bcd_seq_adder.sv
// N-digit BCD adder processing one digit per cycle, with start/busy/done handshake,
// non-BCD detection and per-digit seven-segment outputs driven from the published sum.
module bcd_seq_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*DIGITS-1:0]     a,
    input  logic [4*DIGITS-1:0]     b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     sum,
    output logic                    cout,
    output logic                    invalid,
    output logic [DIGITS-1:0][0:6]  seg
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t state, state_next;

    logic [W-1:0]     a_reg, b_reg, res_reg, res_next;
    logic [IDX_W-1:0] idx;
    logic             carry, carry_next;
    logic             inv_acc, inv_next;
    logic [3:0]       a_dig, b_dig, dig;
    logic [4:0]       t;
    logic             last_digit;

    assign last_digit = (idx == LAST_IDX);

    // One digit slice of the adder; the merged result lets the final digit be published on the same edge.
    always_comb begin
        a_dig      = a_reg[4*idx +: 4];
        b_dig      = b_reg[4*idx +: 4];
        t          = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};
        dig        = t[3:0];
        carry_next = 1'b0;
        if (t > {1'b0, BCD_MAX}) begin
            dig        = t[3:0] + BCD_ADJ;
            carry_next = 1'b1;
        end
        inv_next            = inv_acc | ~is_bcd(a_dig) | ~is_bcd(b_dig);
        res_next            = res_reg;
        res_next[4*idx +: 4] = dig;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Working registers load on an accepted start; published outputs only move on DONE entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            inv_acc <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        carry   <= cin;
                        idx     <= '0;
                        inv_acc <= 1'b0;
                        res_reg <= '0;
                    end
                end
                ADD: begin
                    res_reg <= res_next;
                    carry   <= carry_next;
                    inv_acc <= inv_next;
                    idx     <= idx + 1'b1;
                    if (last_digit) begin
                        sum     <= res_next;
                        cout    <= carry_next;
                        invalid <= inv_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_seg
        bcd_seg7 u_seg7 (
            .digit (sum[4*i +: 4]),
            .seg   (seg[i])
        );
    end

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Self-checking bench for bcd_seq_adder (DIGITS=4): directed cases plus random operands vs a digit-rule model.
module tb_bcd_seq_adder;

    localparam int DIGITS = 4;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic [15:0]            a;
    logic [15:0]            b;
    logic                   cin;
    logic                   busy;
    logic                   done;
    logic [15:0]            sum;
    logic                   cout;
    logic                   invalid;
    logic [DIGITS-1:0][0:6] seg;

    int num_cmp = 0;
    int num_err = 0;

    bcd_seq_adder #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid),
        .seg     (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digit-by-digit addition, returns {invalid, cout, sum}.
    function automatic logic [17:0] refAdd(input logic [15:0] x, input logic [15:0] y, input logic c);
        int xi, yi, t, d, carry;
        logic [15:0] s;
        logic inv;
        s = '0;
        inv = 1'b0;
        carry = int'(c);
        for (int i = 0; i < DIGITS; i++) begin
            xi = int'(x[4*i +: 4]);
            yi = int'(y[4*i +: 4]);
            t = xi + yi + carry;
            if (t > 9) begin
                d = (t + 6) % 16;
                carry = 1;
            end else begin
                d = t;
                carry = 0;
            end
            s[4*i +: 4] = 4'(d);
            if (xi > 9 || yi > 9) inv = 1'b1;
        end
        return {inv, (carry == 1), s};
    endfunction

    function automatic logic [6:0] segRef(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        num_cmp++;
        assert (observed === expected) else begin
            num_err++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkSeg(input string tag, input logic [15:0] exp_sum);
        logic [6:0] s;
        for (int i = 0; i < DIGITS; i++) begin
            s = seg[i];
            checkOutput($sformatf("%s_seg%0d", tag, i), 64'(s), 64'(segRef(exp_sum[4*i +: 4])));
        end
    endtask

    // Start one addition, scramble operands afterwards, and check handshake timing and results.
    task automatic applyStimulus(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c);
        int lat;
        bit busy_bad;
        logic [17:0] expv;
        expv = refAdd(x, y, c);
        @(negedge clk);
        a = x;
        b = y;
        cin = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
        lat = 1;
        busy_bad = 1'b0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_done_seen"}, 64'(done), 64'd1);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(DIGITS + 1));
        checkOutput({tag, "_busy_during_add"}, 64'(busy_bad), 64'd0);
        checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        checkOutput({tag, "_sum"}, 64'(sum), 64'(expv[15:0]));
        checkOutput({tag, "_cout"}, 64'(cout), 64'(expv[16]));
        checkOutput({tag, "_invalid"}, 64'(invalid), 64'(expv[17]));
        checkSeg(tag, expv[15:0]);
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulse_end"}, 64'(done), 64'd0);
        checkOutput({tag, "_sum_hold"}, 64'(sum), 64'(expv[15:0]));
    endtask

    initial begin
        int pulses;
        int first_pulse;
        int spacing;
        int done_seen;
        bit overlap;
        logic [15:0] x, y;

        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_sum", 64'(sum), 64'h0000);
        checkOutput("rst_cout", 64'(cout), 64'd0);
        checkOutput("rst_invalid", 64'(invalid), 64'd0);
        checkSeg("rst", 16'h0000);

        applyStimulus("basic", 16'h1234, 16'h5678, 1'b0);
        checkOutput("basic_sum_const", 64'(sum), 64'h6912);
        checkOutput("basic_seg0_two", 64'(7'(seg[0])), 64'(7'b0010010));
        applyStimulus("fullcarry", 16'h9999, 16'h0000, 1'b1);
        checkOutput("fullcarry_cout_const", 64'(cout), 64'd1);
        applyStimulus("nonbcd", 16'h00A5, 16'h0001, 1'b0);
        checkOutput("nonbcd_sum_const", 64'(sum), 64'h0106);

        // start held high for ten edges: expect two adds, done pulses six cycles apart
        @(negedge clk);
        a = 16'h0405;
        b = 16'h0307;
        cin = 1'b0;
        start = 1'b1;
        pulses = 0;
        first_pulse = 0;
        spacing = 0;
        overlap = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            #1;
            if (e == 10) start = 1'b0;
            if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
            if (done === 1'b1) begin
                pulses++;
                if (pulses == 1) first_pulse = e;
                else if (pulses == 2) spacing = e - first_pulse;
            end
        end
        checkOutput("held_pulses", 64'(pulses), 64'd2);
        checkOutput("held_spacing", 64'(spacing), 64'(DIGITS + 2));
        checkOutput("held_no_overlap", 64'(overlap), 64'd0);
        checkOutput("held_sum", 64'(sum), 64'h0712);

        // Reset in the middle of ADD must discard the partial result
        applyStimulus("pre_abort", 16'h1234, 16'h5678, 1'b0);
        @(negedge clk);
        a = 16'h4444;
        b = 16'h4444;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_sum", 64'(sum), 64'h0000);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkSeg("abort", 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        checkOutput("abort_no_done", 64'(done_seen), 64'd0);
        checkOutput("abort_sum_idle", 64'(sum), 64'h0000);
        applyStimulus("post_abort", 16'h0001, 16'h0001, 1'b0);
        checkOutput("post_abort_sum_const", 64'(sum), 64'h0002);

        // Random operands: mostly valid BCD, every fourth uses raw nibbles
        for (int n = 0; n < 16; n++) begin
            x = '0;
            y = '0;
            for (int i = 0; i < DIGITS; i++) begin
                if (n % 4 == 3) begin
                    x[4*i +: 4] = 4'($urandom_range(0, 15));
                    y[4*i +: 4] = 4'($urandom_range(0, 15));
                end else begin
                    x[4*i +: 4] = 4'($urandom_range(0, 9));
                    y[4*i +: 4] = 4'($urandom_range(0, 9));
                end
            end
            applyStimulus($sformatf("rand%0d", n), x, y, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
        $finish;
    end

endmodule
